// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto the single register-file
// write port and keeps a scoreboard of registers awaiting long-latency results.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic [RW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [RW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rd,
    output logic            wb_wen,
    output logic [RW-1:0]   wb_waddr,
    output logic [XLEN-1:0] wb_wdata,
    output logic [NREG-1:0] busy
);

    logic            rr_q, rr_d;
    logic            wb_wen_q, wb_wen_d;
    logic [RW-1:0]   wb_waddr_q, wb_waddr_d;
    logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            contested;
    logic            lsu_win;
    logic            mdu_win;
    logic            any_win;
    logic [RW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    // Grant decision: pipe first, then a lone requester, then rr breaks the tie.
    always_comb begin
        contested = !pipe_valid && lsu_valid && mdu_valid;
        lsu_win   = !pipe_valid && lsu_valid && (!mdu_valid || !rr_q);
        mdu_win   = !pipe_valid && mdu_valid && (!lsu_valid || rr_q);
        any_win   = pipe_valid || lsu_win || mdu_win;
    end

    assign lsu_ready = lsu_win;
    assign mdu_ready = mdu_win;

    always_comb begin
        win_rd   = pipe_rd;
        win_data = pipe_data;
        if (lsu_win) begin
            win_rd   = lsu_rd;
            win_data = lsu_data;
        end else if (mdu_win) begin
            win_rd   = mdu_rd;
            win_data = mdu_data;
        end

        // After a contested grant the pointer prefers the unit that just lost.
        rr_d = rr_q;
        if (contested) begin
            rr_d = lsu_win;
        end

        wb_wen_d   = any_win && (win_rd != '0);
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        if (any_win) begin
            wb_waddr_d = win_rd;
            wb_wdata_d = win_data;
        end

        // Clear before set so a same-register issue supersedes the retiring result.
        busy_d = busy_q;
        if (lsu_win) begin
            busy_d[lsu_rd] = 1'b0;
        end
        if (mdu_win) begin
            busy_d[mdu_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            wb_wen_q   <= wb_wen_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign wb_wen   = wb_wen_q;
    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of grants, write port and scoreboard.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] busy;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: preferred unit after a tie, pending registers, and the last write.
    int          m_pref;       // 0 = LSU preferred, 1 = MDU preferred
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;
    bit          lsu_taken;
    bit          mdu_taken;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pref  = 0;
        m_busy  = '0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Inputs are already driven; check readies mid-cycle, advance the model, check outputs after the edge.
    task automatic step();
        string      who;
        bit [4:0]   rd;
        bit [31:0]  data;
        #1;
        who = "none";
        if (pipe_valid) who = "pipe";
        else if (lsu_valid && mdu_valid) begin
            who    = (m_pref == 0) ? "lsu" : "mdu";
            m_pref = (who == "lsu") ? 1 : 0;
        end
        else if (lsu_valid) who = "lsu";
        else if (mdu_valid) who = "mdu";

        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, who == "lsu"});
        check("mdu_ready", {63'd0, mdu_ready}, {63'd0, who == "mdu"});
        lsu_taken = (who == "lsu");
        mdu_taken = (who == "mdu");

        rd = '0; data = '0;
        if (who == "pipe") begin rd = pipe_rd; data = pipe_data; end
        if (who == "lsu")  begin rd = lsu_rd;  data = lsu_data;  end
        if (who == "mdu")  begin rd = mdu_rd;  data = mdu_data;  end

        m_wen = (who != "none") && (rd != 0);
        if (who != "none") begin
            m_waddr = rd;
            m_wdata = data;
        end
        if (who == "lsu" || who == "mdu") m_busy[rd] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;

        @(posedge clk);
        #1;
        check("wb_wen",   {63'd0, wb_wen},   {63'd0, m_wen});
        check("wb_waddr", {59'd0, wb_waddr}, {59'd0, m_waddr});
        check("wb_wdata", {32'd0, wb_wdata}, {32'd0, m_wdata});
        check("busy",     {32'd0, busy},     {32'd0, m_busy});
    endtask

    task automatic idle_inputs();
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lsu_valid = 0;  lsu_rd = 0;  lsu_data = 0;
        mdu_valid = 0;  mdu_rd = 0;  mdu_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        idle_inputs();
        // Reset with every requester active.
        rst_n = 1'b0;
        pipe_valid = 1; lsu_valid = 1; mdu_valid = 1; issue_valid = 1; issue_rd = 5'd3;
        pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF; lsu_rd = 5'd6; lsu_data = 32'h66;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_wen",   {63'd0, wb_wen},   64'd0);
        check("rst_busy",  {32'd0, busy},     64'd0);
        check("rst_waddr", {59'd0, wb_waddr}, 64'd0);
        check("rst_wdata", {32'd0, wb_wdata}, 64'd0);
        check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        rst_n = 1'b1;
        mdu_valid = 0; issue_valid = 0;

        // Pipe beats a simultaneous load; load follows once the pipe idles.
        step();
        check("pipe_waddr", {59'd0, wb_waddr}, 64'd5);
        check("pipe_wdata", {32'd0, wb_wdata}, 64'hDEADBEEF);
        pipe_valid = 0;
        step();
        check("lsu_after_pipe", {59'd0, wb_waddr}, 64'd6);
        lsu_valid = 0;

        // Contested LSU/MDU: LSU, then MDU, then LSU again (pointer back to LSU).
        lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h11;
        mdu_valid = 1; mdu_rd = 5'd8; mdu_data = 32'h22;
        step();
        check("rr1_waddr", {59'd0, wb_waddr}, 64'd7);
        check("rr1_wdata", {32'd0, wb_wdata}, 64'h11);
        step();
        check("rr2_waddr", {59'd0, wb_waddr}, 64'd8);
        check("rr2_wdata", {32'd0, wb_wdata}, 64'h22);
        mdu_valid = 0;
        step();
        check("rr3_waddr", {59'd0, wb_waddr}, 64'd7);
        lsu_valid = 0;

        // Result to x0 is consumed without a write.
        mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'h55;
        step();
        check("x0_wen", {63'd0, wb_wen}, 64'd0);
        mdu_valid = 0;

        // Scoreboard set, clear, and same-register set-beats-clear.
        issue_valid = 1; issue_rd = 5'd9;
        step();
        check("busy9_set", {63'd0, busy[9]}, 64'd1);
        issue_valid = 0;
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        check("busy9_clr", {63'd0, busy[9]}, 64'd0);
        check("busy9_wen", {63'd0, wb_wen}, 64'd1);
        check("busy9_waddr", {59'd0, wb_waddr}, 64'd9);
        lsu_valid = 0;
        issue_valid = 1; issue_rd = 5'd10;
        step();
        lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'hA0;
        step();
        check("busy10_keep", {63'd0, busy[10]}, 64'd1);
        idle_inputs();

        // Asynchronous reset in the middle of a granted load.
        pipe_valid = 1; pipe_rd = 5'd12; pipe_data = 32'hC0FFEE;
        issue_valid = 1; issue_rd = 5'd4;
        step();
        idle_inputs();
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wen",  {63'd0, wb_wen}, 64'd0);
        check("arst_busy", {32'd0, busy},   64'd0);
        @(posedge clk); #1;
        check("arst_hold_wen", {63'd0, wb_wen}, 64'd0);
        lsu_valid = 0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with producers honouring the hold-until-ready rule.
        lsu_taken = 0; mdu_taken = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!lsu_valid || lsu_taken) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            if (!mdu_valid || mdu_taken) begin
                mdu_valid = ($urandom_range(0, 2) != 0);
                mdu_rd    = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            pipe_valid  = ($urandom_range(0, 3) == 0);
            pipe_rd     = 5'($urandom_range(0, 31));
            pipe_data   = $urandom;
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
